// File: rtl/key_schedule_ctrl.sv
// key_schedule_ctrl: iterative AES-128 key expansion, one 32-bit word per cycle, round keys on a valid/ready stream
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, key_in     one-cycle request to expand key_in (accepted only in IDLE)
//   busy, done        expansion in progress / one-cycle pulse after round 10 is accepted
//   rk_valid, rk_ready, rk_index, rk_data   round-key stream (index 0..10)

module sub_word (
    input  logic [31:0] a,
    output logic [31:0] y
);
    function automatic logic [7:0] gmul(input logic [7:0] p_a, input logic [7:0] p_b);
        logic [7:0] p, x;
        p = '0;
        x = p_a;
        for (int i = 0; i < 8; i++) begin
            if (p_b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // multiplicative inverse as x^254 (0 maps to 0), then the AES affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s, r;
        s = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    always_comb y = {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
endmodule

module key_schedule_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [3:0]   rk_index,
    output logic [127:0] rk_data
);
    typedef enum logic [1:0] {IDLE, EMIT, CALC} state_t;
    state_t       state;
    logic [127:0] cur_key;
    logic [7:0]   rcon;
    logic [1:0]   step;
    logic [31:0]  w0, w1, w2, w3, sw;

    assign {w0, w1, w2, w3} = cur_key;
    assign rk_data = cur_key;

    sub_word u_sub (.a({w3[23:0], w3[31:24]}), .y(sw));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cur_key  <= '0;
            rcon     <= 8'h01;
            rk_index <= '0;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rk_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cur_key  <= key_in;
                    rcon     <= 8'h01;
                    rk_index <= '0;
                    busy     <= 1'b1;
                    rk_valid <= 1'b1;
                    state    <= EMIT;
                end
                EMIT: if (rk_ready) begin
                    rk_valid <= 1'b0;
                    step     <= '0;
                    if (rk_index == 4'd10) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    step <= step + 2'd1;
                    // each step sees the word updated on the previous cycle
                    case (step)
                        2'd0: cur_key[127:96] <= w0 ^ sw ^ {rcon, 24'h0};
                        2'd1: cur_key[95:64]  <= w1 ^ w0;
                        2'd2: cur_key[63:32]  <= w2 ^ w1;
                        default: begin
                            cur_key[31:0] <= w3 ^ w2;
                            rcon          <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                            rk_index      <= rk_index + 4'd1;
                            rk_valid      <= 1'b1;
                            state         <= EMIT;
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// tb_key_schedule_ctrl: known-answer vectors plus randomized backpressure against a word-array key-expansion model
module tb_key_schedule_ctrl;
    logic         clk, rst, start, busy, done, rk_valid, rk_ready;
    logic [127:0] key_in, rk_data;
    logic [3:0]   rk_index;
    int           total, bad;

    key_schedule_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .busy(busy), .done(done),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_index(rk_index), .rk_data(rk_data)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    logic [7:0] sbox [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic [127:0] exp_rk [11];
    logic [127:0] got [11];

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input bit ok, input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, want);
        end
    endtask

    // FIPS-197 word recurrence over a flat 44-word array
    function automatic void expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]], sbox[t[31:24]]} ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    // caller sits at a negedge with the DUT in IDLE
    task automatic apply_start(input logic [127:0] k);
        start = 1;
        key_in = k;
        @(negedge clk);
        start = 0;
    endtask

    // mode 0: always ready; 1: random stalls incl. a 20-cycle hold; 2: ready, with stray starts in EMIT and CALC
    task automatic collect(input int mode, output int cyc);
        int nxt, hold;
        bit held;
        logic [127:0] ld;
        logic [3:0] li;
        nxt = 0; hold = 0; held = 0; cyc = 1; ld = '0; li = '0;
        check(rk_valid === 1'b1, "r0_latency", {127'b0, rk_valid}, 128'd1);
        while (done !== 1'b1 && cyc < 2000) begin
            start = 0;
            if (rk_valid) begin
                if (held) begin
                    check(rk_data === ld, "stall_data", rk_data, ld);
                    check(rk_index === li, "stall_index", {124'b0, rk_index}, {124'b0, li});
                end else begin
                    check(rk_index === 4'(nxt), "rk_index", {124'b0, rk_index}, 128'(nxt));
                    check(nxt < 11 && rk_data === exp_rk[nxt < 11 ? nxt : 10], "rk_data", rk_data,
                          exp_rk[nxt < 11 ? nxt : 10]);
                    hold = 0;
                    if (mode == 1) hold = (nxt == 2) ? 20 : ($urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 6));
                    if (mode == 2 && nxt == 3) begin
                        hold = 2;
                        start = 1;
                        key_in = 128'hffeeddccbbaa99887766554433221100;
                    end
                end
                rk_ready = (hold == 0);
                if (hold == 0) begin
                    if (nxt < 11) got[nxt] = rk_data;
                    nxt++;
                    held = 0;
                end else begin
                    hold--;
                    held = 1;
                    ld = rk_data;
                    li = rk_index;
                end
            end else begin
                rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (mode == 2 && nxt == 6) begin
                    start = 1;
                    key_in = 128'h00112233445566778899aabbccddeeff;
                end
            end
            @(negedge clk);
            cyc++;
        end
        start = 0;
        check(done === 1'b1, "done_seen", {127'b0, done}, 128'd1);
        check(nxt == 11, "rounds_accepted", 128'(nxt), 128'd11);
        check(busy === 1'b0 && rk_valid === 1'b0, "done_idle", {126'b0, busy, rk_valid}, 128'd0);
    endtask

    initial begin
        int cyc;
        bit seen;
        logic [127:0] k;
        total = 0; bad = 0;
        rst = 1; start = 0; key_in = '0; rk_ready = 0;
        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 0, 128'h2b7e151628aed2a6abf7158809cf4f3c};
        vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[3] = '{128'h0, 1, 128'h62636363626363636263636362636363};
        vecs[4] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 10, 128'h13111d7fe3944a17f307a78b4d2b30c5};
        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        check({busy, done, rk_valid} === 3'b000, "reset_flags", {125'b0, busy, done, rk_valid}, 128'd0);
        check(rk_index === 4'd0 && rk_data === 128'd0, "reset_key", rk_data, 128'd0);

        // known answers; every run after the first starts in the previous run's done cycle
        for (int i = 0; i < 6; i++) begin
            expand(vecs[i].key);
            apply_start(vecs[i].key);
            collect(0, cyc);
            check(got[vecs[i].idx] === vecs[i].rk, "kat_round", got[vecs[i].idx], vecs[i].rk);
            check(cyc == 52, "start_to_done", 128'(cyc), 128'd52);
        end

        // random keys under backpressure
        for (int i = 0; i < 5; i++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            expand(k);
            apply_start(k);
            collect(1, cyc);
        end

        // stray starts while busy must not disturb the schedule
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        apply_start(k);
        collect(2, cyc);
        check(got[10] === exp_rk[10], "ignored_start", got[10], exp_rk[10]);

        // reset during step 2 of the CALC that produces round 5
        rk_ready = 1;
        apply_start(k);
        repeat (23) @(negedge clk);
        check(busy === 1'b1 && rk_valid === 1'b0, "pre_rst_calc", {126'b0, busy, rk_valid}, 128'd2);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check({busy, done, rk_valid} === 3'b000, "rst_flags", {125'b0, busy, done, rk_valid}, 128'd0);
        check(rk_index === 4'd0 && rk_data === 128'd0, "rst_key", rk_data, 128'd0);
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done !== 1'b0 || rk_valid !== 1'b0) seen = 1;
        end
        check(seen == 0, "rst_quiet", {127'b0, seen}, 128'd0);
        k = {$urandom, $urandom, $urandom, $urandom};
        expand(k);
        apply_start(k);
        collect(1, cyc);
        check(got[10] === exp_rk[10], "post_rst_round10", got[10], exp_rk[10]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Iterative AES-128 key-expansion sequencer. Loads a 128-bit cipher key, derives round keys 0..10 one 32-bit word per cycle, and hands them out through a valid/ready stream. It contains one `sub_word` instance (four S-boxes), used only for the first word of each round key. It sits between the key-load interface and the round datapath, which consumes round keys in order.

## Interface
Parameters:
- none (AES-128 only: 4-word key, 10 rounds)

Ports:
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to begin expansion of `key_in`
- `key_in`  in  128  cipher key; bits [127:96] = w0, [31:0] = w3 (FIPS-197 byte order, first byte in MSBs)
- `busy`  out  1  high from accepted `start` until the last round key is accepted
- `done`  out  1  one-cycle pulse on the cycle after round key 10 is accepted
- `rk_valid`  out  1  round key on `rk_data` is valid
- `rk_ready`  in  1  consumer accepts round key when `rk_valid && rk_ready` at a rising edge
- `rk_index`  out  4  round number of `rk_data`, 0..10
- `rk_data`  out  128  round key, same word order as `key_in`

## Operation
- State register: IDLE, EMIT, CALC. Also 128-bit `cur_key`, 8-bit `rcon`, 4-bit `rk_index`, 2-bit `step`.
- IDLE: `busy`=0, `rk_valid`=0. If `start`=1, then `cur_key`<=`key_in`, `rcon`<=0x01, `rk_index`<=0, go to EMIT.
- EMIT: `rk_valid`=1, `busy`=1, `rk_data`=`cur_key`. On handshake:
  - if `rk_index`==10, go to IDLE and pulse `done`;
  - otherwise go to CALC with `step`=0.
- CALC: one word per cycle, updated in place, w0..w3 in order:
  - step 0: `temp` = SubWord(RotWord(w3)) xor {`rcon`, 24'h0}, where RotWord(x) = {x[23:0], x[31:24]}. Then w0 <= w0 xor `temp`.
  - step k=1..3: wk <= wk xor (updated w(k-1)).
  - After step 3:
    - `rcon` <= xtime(`rcon`), i.e. shift left 1 and, if bit 7 was set, xor 0x1b (sequence 01,02,04,08,10,20,40,80,1b,36);
    - `rk_index` += 1;
    - go to EMIT.
- `sub_word` input is driven from RotWord(w3) every cycle. Its output is used only at step 0.
- `start` is ignored in EMIT and CALC. A new key is accepted only from IDLE.
- `rk_data` is a direct view of `cur_key` in all states. It is don't-care when `rk_valid`=0 and must not be sampled then.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `rk_valid`=0, `rk_index`=0, `rk_data`=0, `rcon`=0x01, `step`=0.
- `rst` in any state returns to IDLE on that edge and discards the expansion in progress. `done` does not pulse.
- `start` at edge E: `rk_valid`=1 with round 0 (= `key_in`) from the cycle after E.
- Round key n accepted at edge E: CALC occupies the 4 cycles after E. `rk_valid` reasserts with round n+1 in the 5th cycle after E.
- With `rk_ready` held high, the full schedule takes 1 + 11 + 40 = 52 cycles from `start` to `done`.
- While `rk_valid`=1 and `rk_ready`=0, `rk_data` and `rk_index` are held stable indefinitely.
- `done` is high for exactly one cycle, the cycle after the round-10 handshake, with `busy`=0. `start` may be asserted in that same cycle and is accepted.
- The only combinational path is `sub_word` to the w0 update. There is no combinational path from `rk_ready` to any output.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c with `rk_ready`=1:
  - round 0 equals the key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6;
  - `done` 52 cycles after `start`.
- All-zero key:
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
  - `rk_index` steps 0..10 with no gaps or repeats.
- Backpressure: random `rk_ready` stalls, including 20-cycle holds.
  - `rk_data` and `rk_index` stay stable while stalled.
  - Round keys match the reference model.
  - No round key is skipped.
- `start` with a different key in EMIT and in CALC: ignored. Round keys continue for the original key.
- `rst` asserted at step 2 of round 5:
  - next cycle is IDLE with `rk_valid`=0, `busy`=0, `rk_index`=0, `rk_data`=0, and no `done`;
  - a fresh `start` then produces a correct schedule.
- Back-to-back keys: `start` in the `done` cycle with key 000102030405060708090a0b0c0d0e0f.
  - Round 0 appears the next cycle.
  - Round 10 = 13111d7fe3944a17f307a78b4d2b30c5.
